// File: rtl/deck_shuffler_if.sv
// Deck shuffler bus: shuffle/deal handshake, permutation-unit link and deck RAM port.
interface deck_shuffler_if;
  logic        start;
  logic        deal_req;
  logic [5:0]  perm_addr;
  logic [5:0]  mem_rdata;
  logic [11:0] count;
  logic [5:0]  perm_idx;
  logic [5:0]  mem_addr;
  logic [5:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        shuffle_done;
  logic        deal_ack;
  logic [5:0]  card;
  logic [6:0]  cards_left;
  logic        deck_empty;

  modport slave (
    input  start, deal_req, perm_addr, mem_rdata,
    output count, perm_idx, mem_addr, mem_wdata, mem_we, busy,
           shuffle_done, deal_ack, card, cards_left, deck_empty
  );

  modport master (
    output start, deal_req, perm_addr, mem_rdata,
    input  count, perm_idx, mem_addr, mem_wdata, mem_we, busy,
           shuffle_done, deal_ack, card, cards_left, deck_empty
  );
endinterface

// File: rtl/deck_shuffler.sv
// Swap-pass deck shuffler over an external deck RAM (1-cycle read latency), then deals cards in RAM order.
// Macro AUTO_RESHUFFLE_EN: a deal request on an empty READY deck triggers a reshuffle and is then served.
module deck_shuffler #(
  parameter int DECK_SIZE = 52
) (
  input  logic           clk_i,
  input  logic           rst_i,
  deck_shuffler_if.slave bus_if
);
  localparam logic [5:0] LastIdx = 6'(DECK_SIZE - 1);
  localparam logic [6:0] FullCnt = 7'(DECK_SIZE);

  typedef enum logic [3:0] {
    IDLE, INIT, SW_RD_I, SW_RD_J, SW_WR_I, SW_WR_J, READY, DEAL_RD, DEAL_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [5:0]  i_q, i_d;
  logic [5:0]  j_q, j_d;
  logic [5:0]  a_q, a_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [6:0]  left_q, left_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      ptr_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q + 12'd1;
    i_d              = i_q;
    j_d              = j_q;
    a_d              = a_q;
    ptr_d            = ptr_q;
    left_d           = left_q;
    done_d           = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_we    = 1'b0;
    bus_if.deal_ack  = 1'b0;
    bus_if.card      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          state_d = INIT;
          i_d     = '0;
        end
      end
      INIT: begin
        bus_if.mem_addr  = i_q;
        bus_if.mem_wdata = i_q;
        bus_if.mem_we    = 1'b1;
        if (i_q == LastIdx) begin
          i_d     = '0;
          state_d = SW_RD_I;
        end else begin
          i_d = i_q + 6'd1;
        end
      end
      SW_RD_I: begin
        bus_if.mem_addr = i_q;
        j_d             = bus_if.perm_addr;
        state_d         = SW_RD_J;
      end
      SW_RD_J: begin
        bus_if.mem_addr = j_q;
        a_d             = bus_if.mem_rdata;
        state_d         = SW_WR_I;
      end
      // Read data here is deck[j]; writing it straight back to i keeps i==j a no-op.
      SW_WR_I: begin
        bus_if.mem_addr  = i_q;
        bus_if.mem_wdata = bus_if.mem_rdata;
        bus_if.mem_we    = 1'b1;
        state_d          = SW_WR_J;
      end
      SW_WR_J: begin
        bus_if.mem_addr  = j_q;
        bus_if.mem_wdata = a_q;
        bus_if.mem_we    = 1'b1;
        if (i_q == LastIdx) begin
          state_d = READY;
          i_d     = '0;
          ptr_d   = '0;
          left_d  = FullCnt;
          done_d  = 1'b1;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = SW_RD_I;
        end
      end
      READY: begin
        if (bus_if.start) begin
          state_d = INIT;
          i_d     = '0;
        end else if (bus_if.deal_req && (left_q != 7'd0)) begin
          state_d = DEAL_RD;
        end
`ifdef AUTO_RESHUFFLE_EN
        else if (bus_if.deal_req) begin
          state_d = INIT;
          i_d     = '0;
        end
`endif
      end
      DEAL_RD: begin
        bus_if.mem_addr = ptr_q;
        state_d         = DEAL_OUT;
      end
      DEAL_OUT: begin
        bus_if.deal_ack = 1'b1;
        bus_if.card     = bus_if.mem_rdata;
        ptr_d           = ptr_q + 6'd1;
        left_d          = left_q - 7'd1;
        state_d         = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.count        = count_q;
  assign bus_if.perm_idx     = i_q;
  assign bus_if.busy         = (state_q == INIT) || (state_q == SW_RD_I) || (state_q == SW_RD_J) ||
                               (state_q == SW_WR_I) || (state_q == SW_WR_J);
  assign bus_if.shuffle_done = done_q;
  assign bus_if.cards_left   = left_q;
  assign bus_if.deck_empty   = (left_q == 7'd0);
endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: RAM and permutation-unit stubs, swap-level deck model, per-scenario checks.
module tb_deck_shuffler;
  localparam int N = 52;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deck_shuffler_if bus();
  deck_shuffler #(.DECK_SIZE(N)) dut (.clk_i(clk), .rst_i(rst), .bus_if(bus));

  int checks = 0;
  int failures = 0;
  int perm_mode = 0;
  logic [5:0] rand_tab [64];
  logic [5:0] ram [64];
  int model [N];

  // Permutation unit stub: swap partner chosen from the current index only.
  always_comb begin
    case (perm_mode)
      1:       bus.perm_addr = 6'((int'(bus.perm_idx) + 1) % N);
      2:       bus.perm_addr = rand_tab[bus.perm_idx];
      default: bus.perm_addr = bus.perm_idx;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  function automatic int partner(input int i);
    case (perm_mode)
      1:       return (i + 1) % N;
      2:       return int'(rand_tab[i]);
      default: return i;
    endcase
  endfunction

  // Reference deck: identity, then swap(deck[i], deck[partner(i)]) for i = 0..N-1.
  task automatic build_model();
    int j, t;
    for (int k = 0; k < N; k++) model[k] = k;
    for (int i = 0; i < N; i++) begin
      j = partner(i);
      t = model[i];
      model[i] = model[j];
      model[j] = t;
    end
  endtask

  task automatic new_random_table();
    for (int k = 0; k < 64; k++) rand_tab[k] = 6'($urandom_range(0, N - 1));
    rand_tab[$urandom_range(0, N - 1)] = rand_tab[0];
    rand_tab[7] = 6'd7;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [11:0] exp_count);
    checks++;
    if ({bus.busy, bus.shuffle_done, bus.deal_ack, bus.mem_we, bus.deck_empty} !== 5'b00001) begin
      failures++;
      $display("FAIL %s flags busy/done/ack/we/empty got %b want 00001", tag,
               {bus.busy, bus.shuffle_done, bus.deal_ack, bus.mem_we, bus.deck_empty});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.perm_idx, bus.card, bus.cards_left} !== 31'd0) begin
      failures++;
      $display("FAIL %s addr/wdata/idx/card/left got %0d/%0d/%0d/%0d/%0d want all 0", tag,
               bus.mem_addr, bus.mem_wdata, bus.perm_idx, bus.card, bus.cards_left);
    end
    checks++;
    if (bus.count !== exp_count) begin
      failures++;
      $display("FAIL %s count got %0d want %0d", tag, bus.count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.deal_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 12'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("idle10", 12'd10);
  endtask

  task automatic test_no_deal_before_start();
    int acks = 0, busy_cnt = 0;
    bus.deal_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.deal_ack === 1'b1) acks++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.deal_req = 1'b0;
    checks++;
    if (acks != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL no_deal_after_reset acks=%0d busy=%0d want 0/0", acks, busy_cnt);
    end
  endtask

  // Caller builds the model first; start (optionally with deal_req) is held for one edge.
  task automatic run_shuffle(input string tag, input bit with_deal);
    int done_cyc = -1, done_cnt = 0, busy_err = 0, late_we = 0, acks = 0, ram_err = 0;
    @(negedge clk); bus.start = 1'b1; bus.deal_req = with_deal;
    @(negedge clk); bus.start = 1'b0; bus.deal_req = 1'b0;
    for (int c = 1; c <= 270; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.shuffle_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.busy !== 1'(c <= 260)) busy_err++;
      if (c > 260 && bus.mem_we !== 1'b0) late_we++;
      if (bus.deal_ack !== 1'b0) acks++;
    end
    checks++;
    if (done_cyc != 261 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s shuffle_done cycle=%0d pulses=%0d want 261/1", tag, done_cyc, done_cnt);
    end
    checks++;
    if (busy_err != 0) begin
      failures++;
      $display("FAIL %s busy window errors=%0d want 0", tag, busy_err);
    end
    checks++;
    if (late_we != 0) begin
      failures++;
      $display("FAIL %s mem_we after shuffle count=%0d want 0", tag, late_we);
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL %s deal_ack during shuffle count=%0d want 0", tag, acks);
    end
    checks++;
    if (bus.cards_left !== 7'(N) || bus.deck_empty !== 1'b0) begin
      failures++;
      $display("FAIL %s cards_left got %0d empty=%b want %0d/0", tag, bus.cards_left, bus.deck_empty, N);
    end
    for (int k = 0; k < N; k++) if (ram[k] !== 6'(model[k])) ram_err++;
    checks++;
    if (ram_err != 0) begin
      failures++;
      $display("FAIL %s ram contents mismatching entries=%0d want 0", tag, ram_err);
    end
  endtask

  task automatic test_identity_shuffle();
    perm_mode = 0;
    build_model();
    run_shuffle("identity", 1'b0);
  endtask

  task automatic test_rotate_shuffle();
    int seen [64];
    int bad = 0;
    perm_mode = 1;
    build_model();
    run_shuffle("rotate", 1'b0);
    for (int k = 0; k < 64; k++) seen[k] = 0;
    for (int k = 0; k < N; k++) seen[ram[k]]++;
    for (int k = 0; k < N; k++) if (seen[k] != 1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rotate_permutation codes not seen once=%0d want 0", bad);
    end
  endtask

  task automatic test_deal_all();
    int acks = 0, first = -1, last = -1, gap_err = 0, card_err = 0;
    @(negedge clk); bus.deal_req = 1'b1;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      if (bus.deal_ack === 1'b1) begin
        if (first < 0) first = c;
        else if (c - last != 3) gap_err++;
        if (acks < N && bus.card !== 6'(model[acks])) card_err++;
        last = c;
        acks++;
`ifdef AUTO_RESHUFFLE_EN
        if (acks == N) bus.deal_req = 1'b0;
`endif
      end
    end
    checks++;
    if (first != 2) begin
      failures++;
      $display("FAIL deal_latency first ack cycle=%0d want 2", first);
    end
    checks++;
    if (gap_err != 0) begin
      failures++;
      $display("FAIL deal_spacing gaps not 3 cycles=%0d want 0", gap_err);
    end
    checks++;
    if (card_err != 0) begin
      failures++;
      $display("FAIL deal_cards mismatching cards=%0d want 0", card_err);
    end
    checks++;
    if (acks != N) begin
      failures++;
      $display("FAIL deal_count acks=%0d want %0d", acks, N);
    end
    checks++;
    if (bus.deck_empty !== 1'b1 || bus.cards_left !== 7'd0) begin
      failures++;
      $display("FAIL deal_empty empty=%b left=%0d want 1/0", bus.deck_empty, bus.cards_left);
    end
  endtask

`ifdef AUTO_RESHUFFLE_EN
  task automatic test_empty_request();
    int busy1 = 0, done_cyc = -1, ack_cyc = -1;
    logic [5:0] got_card = '0;
    perm_mode = 2;
    new_random_table();
    build_model();
    @(negedge clk); bus.deal_req = 1'b1;
    for (int c = 1; c <= 275; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = int'(bus.busy);
      if (bus.shuffle_done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (bus.deal_ack === 1'b1 && ack_cyc < 0) begin
        ack_cyc = c;
        got_card = bus.card;
        bus.deal_req = 1'b0;
      end
    end
    bus.deal_req = 1'b0;
    checks++;
    if (busy1 != 1 || done_cyc != 261 || ack_cyc != 263) begin
      failures++;
      $display("FAIL auto_reshuffle busy@1=%0d done=%0d ack=%0d want 1/261/263", busy1, done_cyc, ack_cyc);
    end
    checks++;
    if (got_card !== 6'(model[0]) || bus.cards_left !== 7'(N - 1)) begin
      failures++;
      $display("FAIL auto_reshuffle card=%0d left=%0d want %0d/%0d", got_card, bus.cards_left, model[0], N - 1);
    end
  endtask
`else
  task automatic test_empty_request();
    int acks = 0, busy_cnt = 0;
    bus.deal_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.deal_ack === 1'b1) acks++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.deal_req = 1'b0;
    checks++;
    if (acks != 0 || busy_cnt != 0 || bus.deck_empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_hold acks=%0d busy=%0d empty=%b want 0/0/1", acks, busy_cnt, bus.deck_empty);
    end
  endtask
`endif

  task automatic test_random_partial_deal();
    int acks = 0, card_err = 0;
    perm_mode = 2;
    new_random_table();
    build_model();
    run_shuffle("random", 1'b0);
    @(negedge clk); bus.deal_req = 1'b1;
    for (int c = 1; c <= 40 && acks < 5; c++) begin
      @(negedge clk);
      if (bus.deal_ack === 1'b1) begin
        if (bus.card !== 6'(model[acks])) card_err++;
        acks++;
        if (acks == 5) bus.deal_req = 1'b0;
      end
    end
    bus.deal_req = 1'b0;
    @(negedge clk);
    checks++;
    if (acks != 5 || card_err != 0 || bus.cards_left !== 7'(N - 5)) begin
      failures++;
      $display("FAIL random_deal acks=%0d card_err=%0d left=%0d want 5/0/%0d", acks, card_err, bus.cards_left, N - 5);
    end
  endtask

  task automatic test_start_wins();
    new_random_table();
    build_model();
    run_shuffle("start_wins", 1'b1);
  endtask

  task automatic test_reset_mid_shuffle();
    perm_mode = 1;
    build_model();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_shuffle", 12'd0);
    rst = 1'b0;
    run_shuffle("after_reset", 1'b0);
  endtask

  task automatic test_reset_mid_deal();
    int acks = 0;
    @(negedge clk); bus.deal_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.deal_ack !== 1'b0 || bus.card !== 6'd0 || bus.cards_left !== 7'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_deal ack=%b card=%0d left=%0d busy=%b want 0/0/0/0",
               bus.deal_ack, bus.card, bus.cards_left, bus.busy);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.deal_ack === 1'b1) acks++;
    end
    bus.deal_req = 1'b0;
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL deal_after_reset acks=%0d want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_no_deal_before_start();
    test_identity_shuffle();
    test_rotate_shuffle();
    test_deal_all();
    test_empty_request();
    test_random_partial_deal();
    test_start_wins();
    test_reset_mid_shuffle();
    test_reset_mid_deal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/deck_shuffler.md
DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 Parameter DECK_SIZE, default 52: number of cards; legal range 2..64.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request a full shuffle (init + swap pass).
REQ-005 Deal_Req  input  1  request next card; level held until Deal_Ack.
REQ-006 Perm_Addr  input  6  swap partner index returned combinationally by the address permutation unit for (Perm_Idx, Count); values 0..DECK_SIZE-1.
REQ-007 Mem_Rdata  input  6  deck RAM read data; valid one cycle after Mem_Addr is presented.
REQ-008 Count  output  12  free-running entropy counter fed to the permutation unit.
REQ-009 Perm_Idx  output  6  current swap index i fed to the permutation unit.
REQ-010 Mem_Addr / Mem_Wdata / Mem_We  output  6/6/1  deck RAM address, write data, write enable.
REQ-011 Busy  output  1  high while shuffling.
REQ-012 Shuffle_Done  output  1  one-cycle pulse when the deck becomes dealable.
REQ-013 Deal_Ack / Card  output  1/6  one-cycle pulse with the dealt card code, valid only while Deal_Ack is high.
REQ-014 Cards_Left / Deck_Empty  output  7/1  undealt card count; high when Cards_Left==0.

Function
REQ-015 Count SHALL increment by 1 every cycle, wrapping 4095->0, independent of state.
REQ-016 States: IDLE, INIT, SW_RD_I, SW_RD_J, SW_WR_I, SW_WR_J, READY, DEAL_RD, DEAL_OUT.
REQ-017 IDLE or READY with Start=1 SHALL go to INIT next cycle; Start in any other state is ignored.
REQ-018 INIT: one write per cycle, Mem_Addr=k, Mem_Wdata=k, Mem_We=1, k=0..DECK_SIZE-1; then SW_RD_I with i=0.
REQ-019 SW_RD_I: Mem_Addr=i, Perm_Idx=i; latch j=Perm_Addr this cycle.
REQ-020 SW_RD_J: Mem_Addr=j; latch a=Mem_Rdata (deck[i]).
REQ-021 SW_WR_I: latch b=Mem_Rdata; write deck[i]=b.
REQ-022 SW_WR_J: write deck[j]=a; if i==DECK_SIZE-1 go READY, else i+1 and SW_RD_I. i==j SHALL leave the deck unchanged.
REQ-023 Shuffle latency: Start sampled at cycle 0 -> Shuffle_Done at cycle 1+DECK_SIZE*5 (261 for 52); Busy high cycles 1..260.
REQ-024 Entering READY SHALL set Cards_Left=DECK_SIZE and deal pointer to 0.
REQ-025 READY with Deal_Req=1, Start=0, Cards_Left>0: DEAL_RD (Mem_Addr=pointer), then DEAL_OUT (Card=Mem_Rdata, Deal_Ack=1, pointer+1, Cards_Left-1), then READY; Deal_Ack exactly 2 cycles after request sampled.
REQ-026 Start and Deal_Req both high in READY: Start wins; no Deal_Ack.
REQ-027 Deal_Req while empty (macro undefined) or while Busy: no Deal_Ack, request held pending.
REQ-028 Mem_We SHALL be 0 in all states except INIT, SW_WR_I, SW_WR_J.

Reset
REQ-029 Reset=1 at any cycle, including mid-shuffle or mid-deal, SHALL on the next edge force IDLE, Count=0, i=0, pointer=0, Cards_Left=0, Deck_Empty=1, Mem_We=0, Busy=0, Shuffle_Done=0, Deal_Ack=0, Card=0, Mem_Addr=0, Mem_Wdata=0, Perm_Idx=0.
REQ-030 After reset, dealing SHALL be impossible until a Start completes.

Configuration
REQ-031 Macro AUTO_RESHUFFLE_EN: when defined, Deal_Req in READY with Cards_Left==0 SHALL start a shuffle exactly as Start does and, once READY, serve the held request; when undefined, the request is never acknowledged until an explicit Start completes.

Verification
REQ-032 Reset then idle 10 cycles -> all outputs at REQ-029 values, Count==10 after 10 post-reset edges.
REQ-033 Start pulse, stub Perm_Addr=Perm_Idx -> Shuffle_Done at cycle 261, RAM holds identity 0..51, Cards_Left=52.
REQ-034 Start, Perm_Addr=(Perm_Idx+1)%52 -> RAM contents a permutation of 0..51 (each code exactly once), no Mem_We after cycle 260.
REQ-035 Deal 52 cards with Deal_Req held -> 52 Deal_Ack pulses 3 cycles apart, Card sequence equals RAM order, then Deck_Empty=1, 53rd request unacknowledged (macro undefined).
REQ-036 Reset asserted at cycle 100 of shuffle -> IDLE next cycle, Busy=0, Mem_We=0; subsequent Start completes normally in 261 cycles.
REQ-037 AUTO_RESHUFFLE_EN defined, empty deck, Deal_Req=1 -> Busy next cycle, Shuffle_Done 261 cycles later, Deal_Ack 2 cycles after READY, Cards_Left=51.
